// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter
//   Round-robin write arbiter in front of a shared WIDTH-bit register.
//   Requesters raise req[i] with their data on wdata[i*WIDTH +: WIDTH].
//   The winner is granted for one cycle. On the following edge its data is
//   written into q, and it receives a one-cycle ack.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      [N_REQ-1:0]        write requests
//   wdata    [N_REQ*WIDTH-1:0]  packed write data, one slice per requester
//   clr      synchronous clear of q; aborts any grant in flight
//   gnt      [N_REQ-1:0]        registered grant, one-hot or zero
//   ack      [N_REQ-1:0]        registered write acknowledge, one-cycle pulse
//   q, qb    [WIDTH-1:0]        shared register value and its complement
//   busy     high while the FSM is in GRANT; this is the FSM state as seen
//            from outside
//   last_id  index of the last requester whose write completed
//
// Handshake: a requester keeps req[i] and its wdata slice stable while
//   gnt[i]=1. If it drops req[i] during the grant cycle, the write is
//   aborted. It should drop req[i] once it sees ack[i]. If it does not, it
//   re-competes behind every other active requester.
//
// Optional build macro: DFF_ARB_ASSERT_EN compiles in the SVA checkers.
module dff_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   clr,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qb,
  output logic                   busy,
  output logic [IDW-1:0]         last_id
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state, state_n;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     gnt_idx;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [N_REQ-1:0]   win_oh;
  logic               do_grant;
  logic               do_write;
  logic [WIDTH-1:0]   wsel;

  // Round-robin search. It starts one past the last writer and wraps.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
  end

  always_comb begin
    wsel = wdata[int'(gnt_idx)*WIDTH +: WIDTH];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and action strobes. clr overrides everything.
  always_comb begin
    state_n  = state;
    do_grant = 1'b0;
    do_write = 1'b0;
    if (clr) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state_n  = GRANT;
            do_grant = 1'b1;
          end
        end
        GRANT: begin
          state_n  = IDLE;
          // A dropped request here is an abort: no write, and ptr is kept.
          do_write = req[gnt_idx];
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath: grant, acknowledge, register and pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      ack     <= '0;
      q       <= '0;
      ptr     <= IDW'(N_REQ - 1);
      gnt_idx <= '0;
      last_id <= '0;
    end else begin
      ack <= '0;
      gnt <= '0;
      if (clr) q <= '0;
      if (do_grant) begin
        gnt     <= win_oh;
        gnt_idx <= win_idx;
      end
      if (do_write) begin
        q            <= wsel;
        ack[gnt_idx] <= 1'b1;
        ptr          <= gnt_idx;
        last_id      <= gnt_idx;
      end
    end
  end

  assign qb   = ~q;
  assign busy = (state == GRANT);

`ifdef DFF_ARB_ASSERT_EN
  a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt))
    else $error("gnt not one-hot/zero: %b", gnt);
  a_ack_onehot: assert property (@(posedge clk) $onehot0(ack))
    else $error("ack not one-hot/zero: %b", ack);
  a_ack_after_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    (ack & ~$past(gnt)) == '0)
    else $error("ack without preceding gnt: %b", ack);
  a_ack_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    (ack != '0) |=> (ack == '0))
    else $error("ack held for two cycles");
  a_qb_inv: assert property (@(posedge clk) qb == ~q)
    else $error("qb != ~q");
  a_rst_q: assert property (@(posedge clk) !rst_n |-> (q == '0))
    else $error("q nonzero during reset");
  a_clr: assert property (@(posedge clk) disable iff (!rst_n)
    clr |=> (ack == '0 && q == '0))
    else $error("clr did not clear q/ack");
  a_busy: assert property (@(posedge clk) busy == (gnt != '0))
    else $error("busy disagrees with gnt");
`else
  // Checkers not compiled in this build.
`endif

endmodule

// File: tb/tb_dff_reg_arbiter.sv
module tb_dff_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic           clr;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [W-1:0]   qb;
  logic           busy;
  logic [1:0]     last_id;

  dff_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .clr(clr),
    .gnt(gnt), .ack(ack), .q(q), .qb(qb), .busy(busy), .last_id(last_id)
  );

  int total = 0;
  int bad   = 0;

  // reference model: transaction view of the arbiter
  bit           m_busy;
  int           m_w;
  int           m_ptr;
  int           m_last;
  logic [W-1:0] m_q;
  logic [N-1:0] m_gnt;
  logic [N-1:0] m_ack;
  logic [W-1:0] exp_q[$];

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = 1;
    return v << i;
  endfunction

  function automatic int rr_pick(int p, logic [N-1:0] r);
    logic [N-1:0] sh;
    for (int k = 1; k <= N; k++) begin
      sh = r >> ((p + k) % N);
      if (sh[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] data_of(int i);
    return wdata[i*W +: W];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_w = 0; m_ptr = N - 1; m_last = 0;
    m_q = '0; m_gnt = '0; m_ack = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] sh;
    if (!rst_n) begin
      model_reset();
    end else if (clr) begin
      m_q = '0; m_gnt = '0; m_ack = '0; m_busy = 0;
    end else if (m_busy) begin
      m_gnt = '0; m_ack = '0; m_busy = 0;
      sh = req >> m_w;
      if (sh[0]) begin
        m_q = data_of(m_w);
        m_ack = onehot(m_w);
        m_ptr = m_w;
        m_last = m_w;
        exp_q.push_back(m_q);
      end
    end else begin
      m_ack = '0;
      if (req != '0) begin
        m_w = rr_pick(m_ptr, req);
        m_gnt = onehot(m_w);
        m_busy = 1;
      end
    end
  endtask

  // one clock: inputs change on negedge, model follows posedge, checks at negedge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '1; wdata = '0; clr = 1'b0;
    model_reset();
    #12;
    total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h want 00", q); end
    total++; if (qb !== 8'hFF) begin bad++; $display("FAIL reset_qb: got %h want ff", qb); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    total++; if (busy !== 1'b0 || last_id !== 2'd0) begin bad++; $display("FAIL reset_busy_last: got %b/%0d want 0/0", busy, last_id); end
    rst_n = 1'b1;
    cycle();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
    req = '0;
    cycle();
    total++; if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL reset_abort: got gnt=%b ack=%b busy=%b want 0000/0000/0", gnt, ack, busy); end
  endtask

  task automatic test_single();
    req = 4'b0100;
    wdata = {8'h01, 8'hA5, 8'h02, 8'h03};
    cycle();
    total++; if (gnt !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL single_gnt: got %b busy=%b want 0100 busy=1", gnt, busy); end
    cycle();
    total++; if (q !== 8'hA5 || qb !== 8'h5A) begin bad++; $display("FAIL single_q: got q=%h qb=%h want a5/5a", q, qb); end
    total++; if (ack !== 4'b0100 || gnt !== 4'b0000) begin bad++; $display("FAIL single_ack: got ack=%b gnt=%b want 0100/0000", ack, gnt); end
    total++; if (last_id !== 2'd2) begin bad++; $display("FAIL single_last_id: got %0d want 2", last_id); end
    req = '0;
    cycle();
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    req = '1;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int n = 0; n < 5; n++) begin
      cycle();
      total++; if (gnt !== onehot(n % N) || ack !== 4'b0000) begin bad++; $display("FAIL contention_gnt%0d: got gnt=%b ack=%b want %b/0000", n, gnt, ack, onehot(n % N)); end
      cycle();
      total++; if (ack !== onehot(n % N) || gnt !== 4'b0000) begin bad++; $display("FAIL contention_ack%0d: got ack=%b gnt=%b want %b/0000", n, ack, gnt, onehot(n % N)); end
      total++; if (q !== W'(((n % N) + 1) * 17)) begin bad++; $display("FAIL contention_q%0d: got %h want %h", n, q, W'(((n % N) + 1) * 17)); end
    end
    req = '0;
    cycle();
  endtask

  task automatic test_abort();
    req = 4'b0010;
    wdata = {8'h10, 8'h3C, 8'h77, 8'h20};
    cycle();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL abort_gnt: got %b want 0010", gnt); end
    req = 4'b1100;
    cycle();
    total++; if (ack !== 4'b0000 || q !== 8'h11 || busy !== 1'b0) begin bad++; $display("FAIL abort_noack: got ack=%b q=%h busy=%b want 0000/11/0", ack, q, busy); end
    total++; if (last_id !== 2'd0) begin bad++; $display("FAIL abort_last_id: got %0d want 0", last_id); end
    cycle();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL abort_next_gnt: got %b want 0100", gnt); end
    cycle();
    total++; if (ack !== 4'b0100 || q !== 8'h3C) begin bad++; $display("FAIL abort_next_write: got ack=%b q=%h want 0100/3c", ack, q); end
    req = '0;
    cycle();
  endtask

  task automatic test_clear();
    req = 4'b1000;
    wdata = {8'hFF, 8'h00, 8'h00, 8'h00};
    cycle();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL clear_gnt: got %b want 1000", gnt); end
    clr = 1'b1;
    cycle();
    total++; if (q !== 8'h00 || qb !== 8'hFF) begin bad++; $display("FAIL clear_q: got q=%h qb=%h want 00/ff", q, qb); end
    total++; if (ack !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL clear_ack: got ack=%b gnt=%b busy=%b want 0000/0000/0", ack, gnt, busy); end
    total++; if (last_id !== 2'd2) begin bad++; $display("FAIL clear_last_id: got %0d want 2", last_id); end
    clr = 1'b0;
    req = '0;
    cycle();
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    wdata = {8'h00, 8'h00, 8'h9E, 8'h00};
    cycle();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rstmid_gnt: got %b want 0010", gnt); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl: got gnt=%b ack=%b busy=%b want 0000/0000/0", gnt, ack, busy); end
    total++; if (q !== 8'h00 || qb !== 8'hFF || last_id !== 2'd0) begin bad++; $display("FAIL rstmid_data: got q=%h qb=%h last=%0d want 00/ff/0", q, qb, last_id); end
    @(negedge clk);
    total++; if (q !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_discard: got q=%h busy=%b want 00/0", q, busy); end
    req = '1;
    rst_n = 1'b1;
    cycle();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rstmid_first_gnt: got %b want 0001", gnt); end
    req = '0;
    cycle();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_v;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) req = '0;
      for (int i = 0; i < N; i++)
        if (!(m_busy && i == m_w)) wdata[i*W +: W] = W'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      cycle();
      total++; if (gnt !== m_gnt) begin bad++; $display("FAIL rand_gnt c=%0d: got %b want %b", c, gnt, m_gnt); end
      total++; if (ack !== m_ack) begin bad++; $display("FAIL rand_ack c=%0d: got %b want %b", c, ack, m_ack); end
      total++; if (q !== m_q || qb !== ~m_q) begin bad++; $display("FAIL rand_q c=%0d: got q=%h qb=%h want %h/%h", c, q, qb, m_q, ~m_q); end
      total++; if (busy !== m_busy || last_id !== 2'(m_last)) begin bad++; $display("FAIL rand_busy_last c=%0d: got %b/%0d want %b/%0d", c, busy, last_id, m_busy, m_last); end
      if (ack !== '0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_sb_empty c=%0d: got ack=%b want no ack", c, ack);
        end else begin
          exp_v = exp_q.pop_front();
          if (q !== exp_v) begin bad++; $display("FAIL rand_sb_data c=%0d: got %h want %h", c, q, exp_v); end
        end
      end
    end
    clr = 1'b0;
    req = '0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_sb_left: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_abort();
    test_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

Round-robin write arbiter for a shared WIDTH-bit D-flip-flop register. Up to N_REQ requesters compete for write access. The block grants one requester at a time, captures that requester's data into the shared register, and acknowledges the write. It sits between producer blocks and the shared register, and it owns the register's q/qb outputs.

## Interface
- N_REQ, 4: number of requesters; must be at least 2.
- WIDTH, 8: width of the shared register.
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- req  in  N_REQ: write request; req[i] belongs to requester i.
- wdata  in  N_REQ*WIDTH: write data; requester i drives wdata[i*WIDTH +: WIDTH].
- clr  in  1: synchronous clear of the register.
- gnt  out  N_REQ: registered grant, one-hot or zero.
- ack  out  N_REQ: registered write acknowledge, a one-cycle pulse.
- q  out  WIDTH: shared register value.
- qb  out  WIDTH: always equal to ~q.
- busy  out  1: high while the state is GRANT.
- last_id  out  $clog2(N_REQ): index of the last requester that completed a write.

## Operation
- Two states: IDLE and GRANT.
- Round-robin pointer `ptr`:
  - Reset value is N_REQ-1, so requester 0 wins first after reset.
  - The search starts at ptr+1, wraps modulo N_REQ, and selects the first i with req[i]=1.
- In IDLE:
  - If req is non-zero and clr=0: set gnt to one-hot(winner), set busy=1, go to GRANT.
  - Otherwise stay in IDLE.
- In GRANT, with granted index w:
  - If req[w]=1: q<=wdata[w], ack[w]<=1, ptr<=w, last_id<=w, gnt<=0, go to IDLE.
  - If req[w]=0 (abort): no write, no ack, ptr unchanged, gnt<=0, go to IDLE.
- wdata[w] is sampled only on the GRANT-state edge. Requester w must hold req[w] and wdata[w] stable while gnt[w]=1.
- clr=1 in any state has priority over everything:
  - q<=0, gnt<=0, ack<=0, next state IDLE.
  - ptr and last_id are unchanged.
  - A write that coincides with clr is dropped and not acked.
- Requests that arrive while in GRANT are not seen until the next IDLE edge.
- A requester should drop req on seeing ack. If it keeps req high, it re-competes at round-robin priority, behind every other active requester.
- qb is purely combinational (~q), so it never differs from ~q for any cycle.
- Reset (asynchronous, any state, including mid-GRANT):
  - q=0, qb=all ones, gnt=0, ack=0, busy=0, last_id=0, ptr=N_REQ-1, state IDLE.
  - A write interrupted by reset is discarded.

## Timing
- Latency, counting from the edge where IDLE samples req: gnt is visible after edge 0; q update and ack are visible after edge 1.
- ack lasts exactly one cycle and coincides with the first cycle q holds the new value.
- Throughput: at most one write every 2 cycles. The IDLE cycle that carries ack may arbitrate again on the following edge.
- Fairness: with all req held high, the grant order is 0,1,…,N_REQ-1,0,… A waiting requester waits at most 2·(N_REQ-1) cycles after the current grant.
- gnt and ack are never non-zero in the same cycle.

## Configuration
- DFF_ARB_ASSERT_EN defined: SVA checkers are compiled in, each firing `$error` on violation:
  - gnt is one-hot or zero.
  - ack is one-hot or zero.
  - ack[i] implies $past(gnt[i]).
  - ack never stays high for two consecutive cycles.
  - qb==~q at every posedge.
  - !rst_n implies q==0.
  - clr implies ack==0 and q==0 on the next cycle.
  - busy==(gnt!=0).
- DFF_ARB_ASSERT_EN not defined: no assertions are compiled. Functional behaviour is identical.

## Test plan
- Reset: rst_n=0 for 12 ns with req=4'b1111 → q=0x00, qb=0xFF, gnt=0, ack=0; after rst_n=1 the first grant is gnt=4'b0001.
- Single requester: req[2]=1, wdata[2]=0xA5 → gnt=4'b0100 after 1 edge; q=0xA5, qb=0x5A, ack=4'b0100 after 2 edges; last_id=2.
- Contention: req=4'b1111 held, distinct data 0x11/0x22/0x33/0x44 → ack order 0,1,2,3,0, one every 2 cycles; q follows the data in the same order.
- Abort: grant requester 1, then drop req[1] during GRANT → no ack, q unchanged, next IDLE grants the next requester after ptr.
- Clear: clr=1 in the GRANT cycle of requester 3 with wdata=0xFF → q=0x00, ack=0, state IDLE, last_id unchanged.
- Reset mid-operation: assert rst_n=0 asynchronously while gnt=4'b0010 → all outputs take their reset values immediately, and requester 0 wins first after reset release.
